// File: rtl/main_fsm.sv
// Multicycle main decoder for the ARM subset (LDR/STR, DP reg/imm, B).
// Moore outputs drive the datapath selects; enables are gated off while reset is held.
module main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               ALUOp,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  // state   | meaning
  // FETCH   | read instruction at PC, PC <= PC+4
  // DECODE  | register read, PC+8 on the result bus
  // MEMADR  | base + offset address compute
  // MEMRD   | memory read at ALUOut
  // MEMWB   | load data written back to Rd
  // MEMWR   | store data written to memory
  // EXECR   | DP op with register operand
  // EXECI   | DP op with immediate operand
  // ALUWB   | ALU result written back to Rd
  // BRANCH  | PC <= PC+8+offset (conditional)
  // UNKNOWN | undecodable Op, parked until reset
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic irwrite_s, nextpc_s, regw_s, memw_s, branch_s, aluop_s;

  logic funct_unused;
  assign funct_unused = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:  state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:   state_d = S_ALUWB;
      S_UNKNOWN: state_d = S_UNKNOWN;
      default:   state_d = S_FETCH;
    endcase
  end

  // Sticky flag rises together with the entry into UNKNOWN
  assign illegal_d = illegal_q | (state_d == S_UNKNOWN);

  always_comb begin
    irwrite_s = 1'b0;
    nextpc_s  = 1'b0;
    regw_s    = 1'b0;
    memw_s    = 1'b0;
    branch_s  = 1'b0;
    aluop_s   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        nextpc_s  = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw_s    = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw_s = 1'b1;
      end
      S_EXECR: aluop_s = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        aluop_s = 1'b1;
      end
      S_ALUWB: regw_s = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch_s  = 1'b1;
      end
      default: ;
    endcase
  end

  // Gating with reset kills any in-flight write the moment reset asserts
  assign IRWrite = irwrite_s & reset;
  assign NextPC  = nextpc_s  & reset;
  assign RegW    = regw_s    & reset;
  assign MemW    = memw_s    & reset;
  assign Branch  = branch_s  & reset;
  assign ALUOp   = aluop_s   & reset;
  assign Illegal = illegal_q;
  assign State   = STATE_W'(state_q);

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: instruction table, random instruction stream,
// illegal-op parking and mid-instruction reset.
module tb_main_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .Illegal(Illegal), .State(State)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {IRWrite,NextPC,RegW,MemW,Branch,ALUOp,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,Illegal}
  wire [13:0] act_out = {IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
                         ALUSrcA, ALUSrcB, ResultSrc, Illegal};

  function automatic logic [13:0] pack(bit irw, bit npc, bit rw, bit mw, bit br, bit ao,
                                       bit adr, logic [1:0] sa, logic [1:0] sb,
                                       logic [1:0] rs, bit ill);
    return {irw, npc, rw, mw, br, ao, adr, sa, sb, rs, ill};
  endfunction

  // Output table by state number, straight from the behaviour description
  function automatic logic [13:0] exp_out(int st);
    case (st)
      0:  return pack(1,1,0,0,0,0,0,2'b01,2'b10,2'b10,0);
      1:  return pack(0,0,0,0,0,0,0,2'b01,2'b10,2'b10,0);
      2:  return pack(0,0,0,0,0,0,0,2'b00,2'b01,2'b00,0);
      3:  return pack(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0);
      4:  return pack(0,0,1,0,0,0,0,2'b00,2'b00,2'b01,0);
      5:  return pack(0,0,0,1,0,0,1,2'b00,2'b00,2'b00,0);
      6:  return pack(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
      7:  return pack(0,0,0,0,0,1,0,2'b00,2'b01,2'b00,0);
      8:  return pack(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0);
      9:  return pack(0,0,0,0,1,0,0,2'b00,2'b01,2'b10,0);
      10: return pack(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);
      default: return '0;
    endcase
  endfunction

  localparam logic [13:0] RESET_OUT = 14'b0000000_01_10_10_0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Instruction-class model: list of states visited, FETCH first
  function automatic int model_seq(input logic [1:0] op, input logic [5:0] f, output int s[6]);
    s = '{0, 1, 0, 0, 0, 0};
    if (op == 2'b01 && f[0])  begin s[2] = 2; s[3] = 3; s[4] = 4; return 5; end
    if (op == 2'b01)          begin s[2] = 2; s[3] = 5; return 4; end
    if (op == 2'b00 && f[5])  begin s[2] = 7; s[3] = 8; return 4; end
    if (op == 2'b00)          begin s[2] = 6; s[3] = 8; return 4; end
    if (op == 2'b10)          begin s[2] = 9; return 3; end
    return 0;
  endfunction

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    int         len;
    int         st[6];
  } vec_t;

  function automatic vec_t mk(string n, logic [1:0] o, logic [5:0] f, int l,
                              int a2, int a3, int a4);
    vec_t v;
    v.name = n; v.op = o; v.funct = f; v.len = l;
    v.st[0] = 0; v.st[1] = 1; v.st[2] = a2; v.st[3] = a3; v.st[4] = a4; v.st[5] = 0;
    return v;
  endfunction

  // Entered just after a negedge with the DUT in FETCH; leaves it the same way
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] f,
                           input int len, input int st[6]);
    Op = op;
    Funct = f;
    for (int i = 0; i < len; i++) begin
      if (i != 0) begin
        @(negedge clk);
        #1;
      end
      chk({name, "_state"}, 32'(State), 32'(st[i]));
      chk({name, "_outs"}, 32'(act_out), 32'(exp_out(st[i])));
    end
    @(negedge clk);
    #1;
    chk({name, "_retire"}, 32'(State), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int s[6];
    int len;
    logic [1:0] rop;
    logic [5:0] rf;

    tbl[0] = mk("ldr",  2'b01, 6'b011001, 5, 2, 3, 4);
    tbl[1] = mk("str",  2'b01, 6'b011000, 4, 2, 5, 0);
    tbl[2] = mk("addi", 2'b00, 6'b101000, 4, 7, 8, 0);
    tbl[3] = mk("addr", 2'b00, 6'b001000, 4, 6, 8, 0);
    tbl[4] = mk("b",    2'b10, 6'b000000, 3, 9, 0, 0);
    tbl[5] = mk("ldri", 2'b01, 6'b111111, 5, 2, 3, 4);

    reset = 1'b0;
    Op = 2'b00;
    Funct = 6'b000000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_outs", 32'(act_out), 32'(RESET_OUT));
    reset = 1'b1;
    #1;
    chk("rel_irwrite", 32'(IRWrite), 32'd1);
    chk("rel_nextpc", 32'(NextPC), 32'd1);

    for (int i = 0; i < 6; i++)
      run_instr(tbl[i].name, tbl[i].op, tbl[i].funct, tbl[i].len, tbl[i].st);

    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 2));
      rf  = 6'($urandom);
      len = model_seq(rop, rf, s);
      run_instr("rand", rop, rf, len, s);
    end

    // Illegal opcode parks in UNKNOWN with sticky Illegal
    Op = 2'b11;
    Funct = 6'($urandom);
    chk("ill_fetch", 32'(State), 32'd0);
    @(negedge clk); #1;
    chk("ill_decode", 32'(State), 32'd1);
    chk("ill_decode_flag", 32'(Illegal), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      Op = 2'($urandom);
      chk("ill_park_state", 32'(State), 32'd10);
      chk("ill_park_outs", 32'(act_out), 32'(exp_out(10)));
    end
    reset = 1'b0;
    #1;
    chk("ill_rst_state", 32'(State), 32'd0);
    chk("ill_rst_flag", 32'(Illegal), 32'd0);
    chk("ill_rst_outs", 32'(act_out), 32'(RESET_OUT));
    @(negedge clk); #1;
    reset = 1'b1;
    #1;

    // Reset during LDR writeback kills RegW immediately
    Op = 2'b01;
    Funct = 6'b011001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
    end
    chk("mid_state4", 32'(State), 32'd4);
    chk("mid_regw_before", 32'(RegW), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_regw_after", 32'(RegW), 32'd0);
    chk("mid_state_after", 32'(State), 32'd0);
    chk("mid_outs_after", 32'(act_out), 32'(RESET_OUT));
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    run_instr("post_rst", tbl[4].op, tbl[4].funct, tbl[4].len, tbl[4].st);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
